// File: rtl/operand_entry_if.sv
// Key-event, compute-request and display signals between the calculator
// environment and operand_entry. slave = operand_entry, master = its surroundings.
interface operand_entry_if #(
  parameter int DATA_W = 16
) ();
  logic              KeyRdy;
  logic              KeyRd;
  logic [3:0]        keypad_input;
  logic [2:0]        operator_input;
  logic              equal_input;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_code;
  logic              calc_valid;
  logic              calc_ready;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic [DATA_W-1:0] display_value;
  logic              entry_err;

  modport slave (
    input  KeyRdy, keypad_input, operator_input, equal_input,
    input  calc_ready, result, result_valid,
    output KeyRd, op_a, op_b, op_code, calc_valid, display_value, entry_err
  );

  modport master (
    output KeyRdy, keypad_input, operator_input, equal_input,
    output calc_ready, result, result_valid,
    input  KeyRd, op_a, op_b, op_code, calc_valid, display_value, entry_err
  );
endinterface

// File: rtl/operand_entry.sv
// Calculator operand entry: assembles decimal key digits into signed operands,
// issues compute requests to the ALU and drives the display value.
//
// state   | meaning
// S_A     | entering operand A
// S_B     | operator chosen, entering operand B
// S_ISSUE | compute request held until ALU accepts
// S_WAIT  | waiting for ALU result strobe
// S_DONE  | result shown, next digit starts new entry
module operand_entry #(
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           nRST,
  operand_entry_if.slave bus
);

  localparam logic [DATA_W+3:0] MAG_MAX = {5'd0, {(DATA_W-1){1'b1}}};
  localparam logic [2:0]        OP_SUB  = 3'b010;
  localparam logic [2:0]        OP_CLR  = 3'b111;

  typedef enum logic [2:0] {S_A, S_B, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {K_IDLE, K_ACK, K_REL} kstate_t;

  state_t            r_state;
  kstate_t           r_kstate;
  logic              r_key_rd;
  logic [3:0]        r_key_d;
  logic [2:0]        r_key_op;
  logic              r_key_eq;
  logic [DATA_W-1:0] r_mag_a, r_mag_b;
  logic              r_neg_a, r_neg_b;
  logic              r_seen_a, r_seen_b;
  logic [2:0]        r_op_code, r_pend_op;
  logic              r_calc_valid;
  logic [DATA_W-1:0] r_display;
  logic              r_entry_err;

  logic [DATA_W-1:0] w_sa, w_sb, w_disp, w_res_mag;
  logic [DATA_W+3:0] w_acc_a, w_acc_b;
  logic              w_ok_a, w_ok_b, w_res_neg;
  logic              w_key_en, w_proc, w_is_dig, w_is_op, w_is_eq, w_is_clr;

  assign w_sa = (r_mag_a ^ {DATA_W{r_neg_a}}) + DATA_W'(r_neg_a);
  assign w_sb = (r_mag_b ^ {DATA_W{r_neg_b}}) + DATA_W'(r_neg_b);

  // mag*10 + d as shift-add, wide enough that overflow is visible
  assign w_acc_a = ({4'd0, r_mag_a} << 3) + ({4'd0, r_mag_a} << 1) + {{DATA_W{1'b0}}, r_key_d};
  assign w_acc_b = ({4'd0, r_mag_b} << 3) + ({4'd0, r_mag_b} << 1) + {{DATA_W{1'b0}}, r_key_d};
  assign w_ok_a  = (w_acc_a <= MAG_MAX);
  assign w_ok_b  = (w_acc_b <= MAG_MAX);

  assign w_res_neg = bus.result[DATA_W-1];
  assign w_res_mag = (bus.result ^ {DATA_W{w_res_neg}}) + DATA_W'(w_res_neg);

  assign w_key_en = (r_state == S_A) || (r_state == S_B) || (r_state == S_DONE);
  assign w_proc   = (r_kstate == K_ACK);
  assign w_is_eq  = r_key_eq;
  assign w_is_clr = !r_key_eq && (r_key_op == OP_CLR);
  assign w_is_op  = !r_key_eq && (r_key_op >= 3'b001) && (r_key_op <= 3'b100);
  assign w_is_dig = !r_key_eq && (r_key_op == 3'b000) && (r_key_d <= 4'd9);

  always_comb begin
    w_disp = w_sa;
    case (r_state)
      S_A:              w_disp = w_sa;
      S_B:              w_disp = r_seen_b ? w_sb : w_sa;
      S_ISSUE, S_WAIT:  w_disp = w_sb;
      S_DONE:           w_disp = w_sa;
      default:          w_disp = w_sa;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state      <= S_A;
      r_kstate     <= K_IDLE;
      r_key_rd     <= 1'b0;
      r_key_d      <= '0;
      r_key_op     <= '0;
      r_key_eq     <= 1'b0;
      r_mag_a      <= '0;
      r_mag_b      <= '0;
      r_neg_a      <= 1'b0;
      r_neg_b      <= 1'b0;
      r_seen_a     <= 1'b0;
      r_seen_b     <= 1'b0;
      r_op_code    <= '0;
      r_pend_op    <= '0;
      r_calc_valid <= 1'b0;
      r_display    <= '0;
      r_entry_err  <= 1'b0;
    end else begin
      r_key_rd  <= 1'b0;
      r_display <= w_disp;

      // Key handshake: capture once, acknowledge once, then wait for release
      case (r_kstate)
        K_IDLE: if (w_key_en && bus.KeyRdy) begin
          r_key_d  <= bus.keypad_input;
          r_key_op <= bus.operator_input;
          r_key_eq <= bus.equal_input;
          r_key_rd <= 1'b1;
          r_kstate <= K_ACK;
        end
        K_ACK:   r_kstate <= K_REL;
        K_REL:   if (!bus.KeyRdy) r_kstate <= K_IDLE;
        default: r_kstate <= K_IDLE;
      endcase

      if (w_proc && w_is_clr) begin
        r_state      <= S_A;
        r_mag_a      <= '0;
        r_mag_b      <= '0;
        r_neg_a      <= 1'b0;
        r_neg_b      <= 1'b0;
        r_seen_a     <= 1'b0;
        r_seen_b     <= 1'b0;
        r_op_code    <= '0;
        r_pend_op    <= '0;
        r_calc_valid <= 1'b0;
        r_display    <= '0;
        r_entry_err  <= 1'b0;
      end else begin
        case (r_state)
          S_A: if (w_proc) begin
            if (w_is_dig) begin
              if (w_ok_a) begin
                r_mag_a  <= w_acc_a[DATA_W-1:0];
                r_seen_a <= 1'b1;
              end else begin
                r_entry_err <= 1'b1;
              end
            end else if (w_is_op) begin
              if (r_seen_a) begin
                r_op_code   <= r_key_op;
                r_entry_err <= 1'b0;
                r_state     <= S_B;
              end else if (r_key_op == OP_SUB) begin
                r_neg_a <= ~r_neg_a;
              end
            end
          end
          S_B: if (w_proc) begin
            if (w_is_dig) begin
              if (w_ok_b) begin
                r_mag_b  <= w_acc_b[DATA_W-1:0];
                r_seen_b <= 1'b1;
              end else begin
                r_entry_err <= 1'b1;
              end
            end else if (w_is_op) begin
              if (r_seen_b) begin
                r_pend_op    <= r_key_op;
                r_calc_valid <= 1'b1;
                r_state      <= S_ISSUE;
              end else if (r_key_op == OP_SUB) begin
                r_neg_b <= ~r_neg_b;
              end else begin
                r_op_code <= r_key_op;
              end
            end else if (w_is_eq && r_seen_b) begin
              r_calc_valid <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end
          S_ISSUE: if (r_calc_valid && bus.calc_ready) begin
            r_calc_valid <= 1'b0;
            r_state      <= S_WAIT;
          end
          S_WAIT: if (bus.result_valid) begin
            r_mag_a  <= w_res_mag;
            r_neg_a  <= w_res_neg;
            r_seen_a <= 1'b1;
            r_mag_b  <= '0;
            r_neg_b  <= 1'b0;
            r_seen_b <= 1'b0;
            if (r_pend_op != 3'b000) begin
              r_op_code <= r_pend_op;
              r_pend_op <= '0;
              r_state   <= S_B;
            end else begin
              r_state <= S_DONE;
            end
          end
          S_DONE: if (w_proc) begin
            if (w_is_dig) begin
              r_mag_a  <= {{(DATA_W-4){1'b0}}, r_key_d};
              r_neg_a  <= 1'b0;
              r_seen_a <= 1'b1;
              r_state  <= S_A;
            end else if (w_is_op) begin
              r_op_code <= r_key_op;
              r_state   <= S_B;
            end
          end
          default: r_state <= S_A;
        endcase
      end
    end
  end

  assign bus.KeyRd         = r_key_rd;
  assign bus.op_a          = w_sa;
  assign bus.op_b          = w_sb;
  assign bus.op_code       = r_op_code;
  assign bus.calc_valid    = r_calc_valid;
  assign bus.display_value = r_display;
  assign bus.entry_err     = r_entry_err;

endmodule
